flash_arbiter: RTL and testbench

- Two-requester arbiter and transaction sequencer in front of the SPI flash controller's stb/ack/rty slave port.
- Requester 0 is the sample/patch fetch engine; requester 1 is the configuration/CPU path.
- Grants the flash round-robin and holds the slave request stable for the whole transaction.
- Retries on rty after a backoff, with a bounded retry count and a timeout, then forces a post-transaction stb-low gap so the flash controller returns to idle.

---
 rtl/flash_arbiter.sv | 155 +++++++++++++++
 tb/tb_flash_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_arbiter.sv
// Two-requester round-robin arbiter and transaction sequencer for the SPI
// flash controller slave port, with retry backoff, timeout and idle gap.
module flash_arbiter #(
    parameter int RETRY_MAX      = 15,
    parameter int BACKOFF_CYCLES = 64,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [23:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [23:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_rty_i
);

    localparam int RW = $clog2(RETRY_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(BACKOFF_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [RW-1:0] RTY_LAST = RW'(RETRY_MAX);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BO_LAST  = BW'(BACKOFF_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        BACKOFF,
        GAP
    } state_t;

    state_t        state;
    logic          last_grant;
    logic [RW-1:0] retry_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [BW-1:0] bo_cnt;
    logic [GW-1:0] gap_cnt;
    logic          gnt_stb;
    logic          nxt_gnt;

    // last_grant doubles as the owner of the transaction in flight
    assign gnt_stb = last_grant ? m1_stb_i : m0_stb_i;
    assign nxt_gnt = (m0_stb_i && m1_stb_i) ? ~last_grant : m1_stb_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            retry_cnt   <= '0;
            timeout_cnt <= '0;
            bo_cnt      <= '0;
            gap_cnt     <= '0;
            s_adr_o     <= '0;
            s_dat_o     <= '0;
            s_we_o      <= 1'b0;
            s_stb_o     <= 1'b0;
            m0_dat_o    <= '0;
            m0_ack_o    <= 1'b0;
            m0_err_o    <= 1'b0;
            m1_dat_o    <= '0;
            m1_ack_o    <= 1'b0;
            m1_err_o    <= 1'b0;
        end else begin
            m0_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m1_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (m0_stb_i || m1_stb_i) begin
                        last_grant  <= nxt_gnt;
                        s_adr_o     <= nxt_gnt ? m1_adr_i : m0_adr_i;
                        s_dat_o     <= nxt_gnt ? m1_dat_i : m0_dat_i;
                        s_we_o      <= nxt_gnt ? m1_we_i : m0_we_i;
                        s_stb_o     <= 1'b1;
                        retry_cnt   <= '0;
                        timeout_cnt <= '0;
                        state       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (timeout_cnt != TO_LAST) begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                    if (!gnt_stb) begin
                        s_stb_o <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else if (s_ack_i) begin
                        if (last_grant) begin
                            m1_dat_o <= s_dat_i;
                            m1_ack_o <= 1'b1;
                        end else begin
                            m0_dat_o <= s_dat_i;
                            m0_ack_o <= 1'b1;
                        end
                        s_stb_o <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else if (s_rty_i && retry_cnt != RTY_LAST) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        bo_cnt    <= '0;
                        s_stb_o   <= 1'b0;
                        state     <= BACKOFF;
                    end else if (s_rty_i || timeout_cnt == TO_LAST) begin
                        m1_err_o <= last_grant;
                        m0_err_o <= ~last_grant;
                        s_stb_o  <= 1'b0;
                        gap_cnt  <= '0;
                        state    <= GAP;
                    end
                end
                BACKOFF: begin
                    if (!gnt_stb) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else if (bo_cnt == BO_LAST) begin
                        s_stb_o <= 1'b1;
                        state   <= ACTIVE;
                    end else begin
                        bo_cnt <= bo_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: grants, gaps, retries, exhaustion,
// timeout, abort and asynchronous reset.
module tb_flash_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [23:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [31:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic        m0_we_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic        m1_we_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic        s_we_o, s_stb_o, s_ack_i, s_rty_i;

    int checks = 0;
    int errors = 0;
    int m0_acks = 0, m0_errs = 0, m1_acks = 0, m1_errs = 0;
    int low, n, nrty, e0, e1, a0;
    bit seen_err, seen_ack;

    flash_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i),
        .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i),
        .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
        .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_rty_i(s_rty_i)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (m0_ack_o) m0_acks++;
        if (m0_err_o) m0_errs++;
        if (m1_ack_o) m1_acks++;
        if (m1_err_o) m1_errs++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // counts samples with s_stb_o low, including the current one
    task automatic wait_high(output int cnt);
        cnt = 0;
        while (s_stb_o !== 1'b1 && cnt < 1000) begin
            cnt++;
            tick();
        end
        chk("stb_rise", s_stb_o, 1);
    endtask

    task automatic serve(input bit g, input logic [23:0] adr,
                         input logic [31:0] wd, input logic we,
                         input logic [31:0] rd, output int cnt);
        wait_high(cnt);
        chk("srv_adr", s_adr_o, adr);
        chk("srv_wdat", s_dat_o, wd);
        chk("srv_we", s_we_o, we);
        repeat (2) tick();
        s_dat_i = rd;
        s_ack_i = 1'b1;
        tick();
        s_ack_i = 1'b0;
        chk("srv_ack", g ? m1_ack_o : m0_ack_o, 1);
        chk("srv_other_ack", g ? m0_ack_o : m1_ack_o, 0);
        chk("srv_err", g ? m1_err_o : m0_err_o, 0);
        chk("srv_rdat", g ? m1_dat_o : m0_dat_o, rd);
    endtask

    initial begin
        rst_i = 1'b1;
        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_stb_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_stb_i = 1'b0;
        s_dat_i = '0; s_ack_i = 1'b0; s_rty_i = 1'b0;
        tick();
        tick();
        chk("rst_stb", s_stb_o, 0);
        chk("rst_adr", s_adr_o, 0);
        chk("rst_wdat", s_dat_o, 0);
        chk("rst_m0dat", m0_dat_o, 0);
        chk("rst_m1ack", m1_ack_o, 0);
        rst_i = 1'b0;
        tick();

        // contention: m0 wins first, then alternation
        m0_adr_i = 24'h000100; m0_dat_i = 32'h0;
        m1_adr_i = 24'h000200; m1_dat_i = 32'hCAFEF00D; m1_we_i = 1'b1;
        m0_stb_i = 1'b1; m1_stb_i = 1'b1;
        serve(0, 24'h000100, 32'h0, 1'b0, 32'h11110000, low);
        m0_stb_i = 1'b0;
        serve(1, 24'h000200, 32'hCAFEF00D, 1'b1, 32'h22220000, low);
        chk("gap_b2b", low, 9);
        m0_stb_i = 1'b1;
        serve(0, 24'h000100, 32'h0, 1'b0, 32'h11110001, low);
        serve(1, 24'h000200, 32'hCAFEF00D, 1'b1, 32'h22220001, low);
        serve(0, 24'h000100, 32'h0, 1'b0, 32'h11110002, low);
        serve(1, 24'h000200, 32'hCAFEF00D, 1'b1, 32'h22220002, low);
        m0_stb_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        repeat (12) tick();

        // single read, ack 10 cycles after stb
        m0_adr_i = 24'h001234;
        m0_stb_i = 1'b1;
        tick();
        chk("rd_stb", s_stb_o, 1);
        chk("rd_adr", s_adr_o, 24'h001234);
        m0_adr_i = 24'hFFFFFF;
        repeat (9) tick();
        chk("rd_adr_hold", s_adr_o, 24'h001234);
        s_dat_i = 32'hDEADBEEF;
        s_ack_i = 1'b1;
        tick();
        s_ack_i = 1'b0;
        m0_stb_i = 1'b0;
        chk("rd_ack", m0_ack_o, 1);
        chk("rd_dat", m0_dat_o, 32'hDEADBEEF);
        chk("rd_stb_low", s_stb_o, 0);
        tick();
        chk("rd_ack_pulse", m0_ack_o, 0);
        low = 0;
        repeat (8) begin
            if (s_stb_o === 1'b0) low++;
            tick();
        end
        chk("rd_gap", low, 8);
        chk("rd_dat_hold", m0_dat_o, 32'hDEADBEEF);
        repeat (4) tick();

        // three retries then ack
        m0_adr_i = 24'h000300;
        m0_stb_i = 1'b1;
        wait_high(low);
        for (int i = 0; i < 3; i++) begin
            s_rty_i = 1'b1;
            tick();
            s_rty_i = 1'b0;
            chk("rty_no_err", m0_err_o, 0);
            wait_high(low);
            chk("backoff_len", low, 64);
        end
        chk("rty_adr", s_adr_o, 24'h000300);
        s_dat_i = 32'h12345678;
        s_ack_i = 1'b1;
        tick();
        s_ack_i = 1'b0;
        m0_stb_i = 1'b0;
        chk("rty_ack", m0_ack_o, 1);
        chk("rty_err", m0_err_o, 0);
        chk("rty_dat", m0_dat_o, 32'h12345678);
        repeat (12) tick();

        // retry exhaustion on m1
        m1_adr_i = 24'h000400;
        m1_stb_i = 1'b1;
        nrty = 0;
        seen_err = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 20 && !seen_err; i++) begin
            wait_high(low);
            s_rty_i = 1'b1;
            tick();
            s_rty_i = 1'b0;
            nrty++;
            if (m1_ack_o) seen_ack = 1'b1;
            if (m1_err_o) seen_err = 1'b1;
        end
        chk("exh_count", nrty, 16);
        chk("exh_err", seen_err, 1);
        chk("exh_no_ack", seen_ack, 0);
        chk("exh_m0_err", m0_err_o, 0);
        tick();
        chk("exh_err_pulse", m1_err_o, 0);
        m1_stb_i = 1'b0;
        repeat (12) tick();

        // timeout: no response at all
        m0_adr_i = 24'h000500;
        m0_stb_i = 1'b1;
        wait_high(low);
        n = 0;
        while (m0_err_o !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, 4096);
        chk("timeout_stb", s_stb_o, 0);
        chk("timeout_ack", m0_ack_o, 0);
        m0_stb_i = 1'b0;
        repeat (12) tick();

        // abort during backoff, m1 waiting behind it
        e0 = m0_errs;
        a0 = m0_acks;
        m0_adr_i = 24'h000600;
        m0_stb_i = 1'b1;
        wait_high(low);
        s_rty_i = 1'b1;
        tick();
        s_rty_i = 1'b0;
        repeat (5) tick();
        m0_stb_i = 1'b0;
        m1_adr_i = 24'h000700;
        m1_dat_i = 32'h0;
        m1_stb_i = 1'b1;
        serve(1, 24'h000700, 32'h0, 1'b0, 32'h77770000, low);
        chk("abort_gap", low, 10);
        chk("abort_no_err", m0_errs - e0, 0);
        chk("abort_no_ack", m0_acks - a0, 0);
        chk("abort_dat", m0_dat_o, 32'h12345678);
        m1_stb_i = 1'b0;
        repeat (12) tick();

        // async reset mid-ACTIVE on an m0 transaction
        m0_adr_i = 24'h000800;
        m0_stb_i = 1'b1;
        wait_high(low);
        repeat (3) tick();
        e0 = m0_errs;
        a0 = m0_acks;
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_stb", s_stb_o, 0);
        chk("arst_adr", s_adr_o, 0);
        chk("arst_dat", m0_dat_o, 0);
        tick();
        rst_i = 1'b0;
        chk("arst_no_err", m0_errs - e0, 0);
        chk("arst_no_ack", m0_acks - a0, 0);
        m1_adr_i = 24'h000900;
        m1_stb_i = 1'b1;
        serve(0, 24'h000800, 32'h0, 1'b0, 32'h88880000, low);
        m0_stb_i = 1'b0;
        serve(1, 24'h000900, 32'h0, 1'b0, 32'h99990000, low);
        m1_stb_i = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
